data_memory_unit: RTL and testbench

DATA_MEMORY_UNIT -- requirements
Module: data_memory_unit

---
 rtl/data_memory_unit.sv | 134 +++++++++++++
 tb/tb_data_memory_unit.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/data_memory_unit.sv
// Word-addressed data memory behind a valid/ready request port with fixed response latency.
// Each accepted request gives one resp_valid pulse. Bad requests raise addr_error and do not touch the array.
module data_memory_unit #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 2
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        mem_read,
  input  logic        mem_write,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic [31:0] memoryOut,
  output logic        resp_valid,
  output logic        addr_error
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_LOAD   = (LATENCY >= 2) ? CW'(LATENCY - 2) : '0;
  localparam logic [32:0]   ADDR_LIMIT = 33'(DEPTH) << 2;

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESPOND} state_t;

  state_t         r_state;
  logic [CW-1:0]  r_count;
  logic [31:0]    r_addr;
  logic [31:0]    r_wdata;
  logic           r_rd;
  logic           r_wr;
  logic           r_req_ready;
  logic           r_resp_valid;
  logic           r_addr_error;
  logic           r_have_data;
  logic [31:0]    r_rd_data;
  logic [31:0]    r_mem [DEPTH];

  logic           w_accept;
  logic           w_go_respond;
  logic [31:0]    w_cur_addr;
  logic [31:0]    w_cur_wdata;
  logic           w_cur_rd;
  logic           w_cur_wr;
  logic           w_err;
  logic [AW-1:0]  w_idx;
  logic           w_do_write;
  logic           w_do_read;

  assign w_accept = req_valid & r_req_ready;

  // With LATENCY=1 the array is accessed on the accept edge itself, so use the live request bus.
  assign w_cur_addr  = (r_state == S_IDLE) ? address    : r_addr;
  assign w_cur_wdata = (r_state == S_IDLE) ? write_data : r_wdata;
  assign w_cur_rd    = (r_state == S_IDLE) ? mem_read   : r_rd;
  assign w_cur_wr    = (r_state == S_IDLE) ? mem_write  : r_wr;

  assign w_go_respond = (LATENCY == 1) ? ((r_state == S_IDLE) && w_accept)
                                       : ((r_state == S_ACCESS) && (r_count == '0));

  assign w_err = (|w_cur_addr[1:0]) | ({1'b0, w_cur_addr} >= ADDR_LIMIT) | (w_cur_rd & w_cur_wr);
  assign w_idx = w_cur_addr[AW+1:2];

  assign w_do_write = reset & w_go_respond & ~w_err & w_cur_wr;
  assign w_do_read  = reset & w_go_respond & ~w_err & w_cur_rd;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= S_IDLE;
      r_count      <= '0;
      r_addr       <= '0;
      r_wdata      <= '0;
      r_rd         <= 1'b0;
      r_wr         <= 1'b0;
      r_req_ready  <= 1'b1;
      r_resp_valid <= 1'b0;
      r_addr_error <= 1'b0;
      r_have_data  <= 1'b0;
    end else begin
      r_resp_valid <= 1'b0;
      r_addr_error <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr      <= address;
            r_wdata     <= write_data;
            r_rd        <= mem_read;
            r_wr        <= mem_write;
            r_req_ready <= 1'b0;
            if (LATENCY == 1) begin
              r_state      <= S_RESPOND;
              r_resp_valid <= 1'b1;
              r_addr_error <= w_err;
            end else begin
              r_state <= S_ACCESS;
              r_count <= CNT_LOAD;
            end
          end
        end
        S_ACCESS: begin
          if (r_count == '0) begin
            r_state      <= S_RESPOND;
            r_resp_valid <= 1'b1;
            r_addr_error <= w_err;
          end else begin
            r_count <= r_count - 1'b1;
          end
        end
        S_RESPOND: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
        default: begin
          r_state     <= S_IDLE;
          r_req_ready <= 1'b1;
        end
      endcase
      if (w_do_read) r_have_data <= 1'b1;
    end
  end

  // Array and read register carry no reset so they map onto block RAM.
  always_ff @(posedge clock) begin
    if (w_do_write) r_mem[w_idx] <= w_cur_wdata;
    if (w_do_read)  r_rd_data    <= r_mem[w_idx];
  end

  assign req_ready  = r_req_ready;
  assign resp_valid = r_resp_valid;
  assign addr_error = r_addr_error;
  assign memoryOut  = r_have_data ? r_rd_data : 32'h0;

endmodule

// File: tb/tb_data_memory_unit.sv
// Directed bench for data_memory_unit (LATENCY=2, DEPTH=256).
// It checks latency, error flagging, load data, throughput and reset abort.
module tb_data_memory_unit;

  logic        clock;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        mem_read;
  logic        mem_write;
  logic [31:0] address;
  logic [31:0] write_data;
  logic [31:0] memoryOut;
  logic        resp_valid;
  logic        addr_error;

  int n_checks = 0;
  int n_pass   = 0;

  data_memory_unit #(.DEPTH(256), .LATENCY(2)) dut (
    .clock      (clock),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .address    (address),
    .write_data (write_data),
    .memoryOut  (memoryOut),
    .resp_valid (resp_valid),
    .addr_error (addr_error)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic req(input string tag, input logic rd, input logic wr,
                     input logic [31:0] addr, input logic [31:0] wdata,
                     input logic exp_err, input logic [31:0] exp_out);
    int n;
    @(negedge clock);
    chk({tag, ":ready"}, {31'h0, req_ready}, 32'h1);
    req_valid  = 1'b1;
    mem_read   = rd;
    mem_write  = wr;
    address    = addr;
    write_data = wdata;
    @(posedge clock);
    @(negedge clock);
    req_valid  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = 32'hFFFF_FFFF;
    write_data = 32'h0;
    n = 1;
    while (!resp_valid && n < 8) begin
      chk({tag, ":err_quiet"}, {31'h0, addr_error}, 32'h0);
      @(negedge clock);
      n++;
    end
    chk({tag, ":latency"}, 32'(n), 32'd2);
    chk({tag, ":resp"}, {31'h0, resp_valid}, 32'h1);
    chk({tag, ":err"}, {31'h0, addr_error}, {31'h0, exp_err});
    chk({tag, ":out"}, memoryOut, exp_out);
    $display("txn %s rd=%0b wr=%0b addr=%h wdata=%h -> lat=%0d err=%0b out=%h",
             tag, rd, wr, addr, wdata, n, addr_error, memoryOut);
  endtask

  initial begin
    int pulses;
    reset      = 1'b0;
    req_valid  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    address    = 32'h0;
    write_data = 32'h0;
    repeat (2) @(negedge clock);
    chk("rst:out", memoryOut, 32'h0);
    chk("rst:resp", {31'h0, resp_valid}, 32'h0);
    chk("rst:err", {31'h0, addr_error}, 32'h0);
    chk("rst:ready", {31'h0, req_ready}, 32'h1);
    reset = 1'b1;

    req("wr10",    1'b0, 1'b1, 32'h10,  32'hDEADBEEF, 1'b0, 32'h0);
    req("rd10",    1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
    req("rd13",    1'b1, 1'b0, 32'h13,  32'h0,        1'b1, 32'hDEADBEEF);
    req("wr400",   1'b0, 1'b1, 32'h400, 32'h12345678, 1'b1, 32'hDEADBEEF);
    req("wr0",     1'b0, 1'b1, 32'h0,   32'hA5A5A5A5, 1'b0, 32'hDEADBEEF);
    req("rd0",     1'b1, 1'b0, 32'h0,   32'h0,        1'b0, 32'hA5A5A5A5);
    req("rdwr10",  1'b1, 1'b1, 32'h10,  32'h55555555, 1'b1, 32'hA5A5A5A5);
    req("rd10b",   1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);
    req("noop10",  1'b0, 1'b0, 32'h10,  32'h77777777, 1'b0, 32'hDEADBEEF);
    req("wr3fc",   1'b0, 1'b1, 32'h3FC, 32'h11112222, 1'b0, 32'hDEADBEEF);
    req("rd3fc",   1'b1, 1'b0, 32'h3FC, 32'h0,        1'b0, 32'h11112222);
    req("rd400",   1'b1, 1'b0, 32'h400, 32'h0,        1'b1, 32'h11112222);
    req("rd10c",   1'b1, 1'b0, 32'h10,  32'h0,        1'b0, 32'hDEADBEEF);

    // Back-to-back reads with req_valid held high
    @(negedge clock);
    req_valid = 1'b1;
    mem_read  = 1'b1;
    mem_write = 1'b0;
    address   = 32'h10;
    pulses    = 0;
    for (int c = 0; c < 9; c++) begin
      chk($sformatf("tput%0d:ready", c), {31'h0, req_ready}, {31'h0, (c % 3) == 0});
      chk($sformatf("tput%0d:resp", c), {31'h0, resp_valid}, {31'h0, (c % 3) == 2});
      if (resp_valid) pulses++;
      if (c < 8) @(negedge clock);
    end
    req_valid = 1'b0;
    mem_read  = 1'b0;
    chk("tput:pulses", 32'(pulses), 32'd3);
    chk("tput:out", memoryOut, 32'hDEADBEEF);
    $display("txn tput: %0d responses in 9 cycles", pulses);

    // Reset during ACCESS aborts a pending write
    @(negedge clock);
    req_valid  = 1'b1;
    mem_write  = 1'b1;
    address    = 32'h10;
    write_data = 32'hCAFEF00D;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    mem_write = 1'b0;
    reset     = 1'b0;
    #1;
    chk("abort:resp", {31'h0, resp_valid}, 32'h0);
    chk("abort:ready", {31'h0, req_ready}, 32'h1);
    chk("abort:out", memoryOut, 32'h0);
    @(negedge clock);
    chk("abort:resp2", {31'h0, resp_valid}, 32'h0);
    reset = 1'b1;
    @(negedge clock);
    chk("abort:resp3", {31'h0, resp_valid}, 32'h0);
    $display("txn abort: write of CAFEF00D to 10 interrupted by reset");
    req("rd10post", 1'b1, 1'b0, 32'h10, 32'h0, 1'b0, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
